// File: rtl/div_seq_32.sv
// Sequential restoring divider: one quotient bit per clock, W+2 cycles per result.
// Define DIV_SIGNED_EN to add the sgn port and two's-complement division.
module div_seq_32 #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
`ifdef DIV_SIGNED_EN
  input  logic         sgn,
`endif
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         dbz,
  output logic         ovf
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [W:0]    rem_reg;
  logic [W-1:0]  quo_reg;
  logic [W-1:0]  div_reg;
  logic          zero_reg;
  logic          neg_q_reg;
  logic          neg_r_reg;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    shifted, diff;
  logic          keep;
  logic          unused_rem;

`ifdef DIV_SIGNED_EN
  logic ovf_case;
  logic ovf_pend_reg;

  assign a_neg    = sgn & A[W-1];
  assign b_neg    = sgn & B[W-1];
  assign ovf_case = sgn && (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // The W+1-bit difference cannot overflow, so its MSB is the borrow.
  assign shifted    = {rem_reg[W-1:0], quo_reg[W-1]};
  assign diff       = shifted - {1'b0, div_reg};
  assign keep       = ~diff[W];
  assign unused_rem = rem_reg[W];

  always_ff @(posedge CLK) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (B == '0) ? FIN : CALC;
      CALC: if (cnt_reg == CW'(W-1)) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Q         <= '0;
      R         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      div_reg   <= '0;
      zero_reg  <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          busy      <= 1'b1;
          cnt_reg   <= '0;
          rem_reg   <= '0;
          div_reg   <= b_mag;
          zero_reg  <= (B == '0);
          neg_q_reg <= a_neg ^ b_neg;
          neg_r_reg <= a_neg;
          // Divide-by-zero parks the raw dividend here so it can be returned as R.
          quo_reg   <= (B == '0) ? A : a_mag;
        end
        CALC: begin
          rem_reg <= keep ? diff : shifted;
          quo_reg <= {quo_reg[W-2:0], keep};
          cnt_reg <= cnt_reg + CW'(1);
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          dbz  <= zero_reg;
          if (zero_reg) begin
            Q <= '1;
            R <= quo_reg;
          end else begin
            Q <= neg_q_reg ? -quo_reg : quo_reg;
            R <= neg_r_reg ? -rem_reg[W-1:0] : rem_reg[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ovf          <= 1'b0;
      ovf_pend_reg <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      ovf_pend_reg <= ovf_case;
    end else if (state_reg == FIN) begin
      ovf <= ~zero_reg & ovf_pend_reg;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_32.sv
// Randomised and directed bench for div_seq_32 against a plain-arithmetic reference.
// Signed cases are exercised only when DIV_SIGNED_EN is defined.
module tb_div_seq_32;
  localparam int W = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST_N, start;
  logic [W-1:0] A, B, Q, R;
  logic         busy, done, dbz, ovf;
`ifdef DIV_SIGNED_EN
  logic         sgn;
`endif

  int checks = 0;
  int errors = 0;

  div_seq_32 #(.W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .A(A), .B(B),
`ifdef DIV_SIGNED_EN
    .sgn(sgn),
`endif
    .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: language arithmetic (truncating division, remainder follows dividend).
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output bit z, output bit o);
    longint sa, sb;
    z = (b == '0);
    o = 1'b0;
    if (z) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      o  = (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input bit disturb, input string tag);
    logic [W-1:0] eq, er;
    bit ez, eo;
    int n, lat;
    ref_div(a, b, s, eq, er, ez, eo);
    lat = (b == '0) ? 1 : W + 1;
    @(negedge CLK);
    A = a; B = b; start = 1'b1;
`ifdef DIV_SIGNED_EN
    sgn = s;
`endif
    @(negedge CLK);
    start = 1'b0;
    check_value({tag, " busy_after_accept"}, busy, 1);
    check_value({tag, " done_after_accept"}, done, 0);
    n = 0;
    while (n < 200) begin
      @(negedge CLK);
      n++;
      if (done) break;
      if (disturb && n == 5) begin
        A = ~a; B = $urandom; start = 1'b1;
      end
      if (disturb && n == 6) start = 1'b0;
    end
    check_value({tag, " latency"}, n, lat);
    check_value({tag, " Q"}, Q, eq);
    check_value({tag, " R"}, R, er);
    check_value({tag, " dbz"}, dbz, ez);
    check_value({tag, " ovf"}, ovf, eo);
    check_value({tag, " busy_in_done"}, busy, 0);
    @(negedge CLK);
    check_value({tag, " done_one_cycle"}, done, 0);
    check_value({tag, " Q_hold"}, Q, eq);
    check_value({tag, " busy_idle"}, busy, 0);
    $display("div %s A=%0h B=%0h s=%0d -> Q=%0h R=%0h dbz=%0d ovf=%0d lat=%0d",
             tag, a, b, s, Q, R, dbz, ovf, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone, nbad, cyc;
    int times[3];
    logic [W-1:0] ra, rb, eq, er;
    bit ez, eo, rs;

    RST_N = 1'b0; start = 1'b0; A = '0; B = '0;
`ifdef DIV_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check_value("reset Q", Q, 0);
    check_value("reset R", R, 0);
    check_value("reset busy", busy, 0);
    check_value("reset done", done, 0);
    check_value("reset dbz", dbz, 0);
    check_value("reset ovf", ovf, 0);
    RST_N = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 1'b0, "basic");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "max_by_one");
    run_div(32'd5, 32'd9, 1'b0, 1'b0, "small_by_big");
    run_div(32'd1234, 32'd0, 1'b0, 1'b0, "div_zero");
    run_div(32'hDEAD_BEEF, 32'd1000, 1'b0, 1'b1, "disturbed");

    // Abort a division with reset part-way through CALC.
    @(negedge CLK);
    A = 32'd999; B = 32'd4; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (9) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check_value("abort Q", Q, 0);
    check_value("abort R", R, 0);
    check_value("abort busy", busy, 0);
    check_value("abort done", done, 0);
    check_value("abort dbz", dbz, 0);
    ndone = 0;
    repeat (W + 5) begin
      @(negedge CLK);
      if (done) ndone++;
    end
    check_value("abort no_done", ndone, 0);
    run_div(32'd81, 32'd9, 1'b0, 1'b0, "after_abort");

    // start held high back-to-back.
    @(negedge CLK);
    A = 32'd77777; B = 32'd13; start = 1'b1;
    ref_div(32'd77777, 32'd13, 1'b0, eq, er, ez, eo);
    ndone = 0; nbad = 0; cyc = 0;
    while (cyc < 4 * (W + 2) + 20) begin
      @(negedge CLK);
      cyc++;
      if (busy && done) nbad++;
      if (done) begin
        times[ndone] = cyc;
        check_value("held Q", Q, eq);
        check_value("held R", R, er);
        $display("held done #%0d at cycle %0d Q=%0h R=%0h", ndone, cyc, Q, R);
        ndone++;
        if (ndone == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    check_value("held count", ndone, 3);
    if (ndone == 3) begin
      check_value("held gap1", times[1] - times[0], W + 2);
      check_value("held gap2", times[2] - times[1], W + 2);
    end
    check_value("held busy_done_overlap", nbad, 0);
    repeat (2) @(negedge CLK);
    check_value("held idle_after", busy, 0);

`ifdef DIV_SIGNED_EN
    run_div(-32'sd7, 32'sd2, 1'b1, 1'b0, "s_neg7_by_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_overflow");
    run_div(32'sd7, -32'sd2, 1'b1, 1'b0, "s_7_by_neg2");
    run_div(-32'sd5, 32'sd0, 1'b1, 1'b0, "s_div_zero");
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 15);
        2:       rb = ra >> $urandom_range(0, 8);
        default: rb = $urandom & 32'h0000_FFFF;
      endcase
      rs = 1'b0;
`ifdef DIV_SIGNED_EN
      rs = $urandom_range(0, 1) == 1;
`endif
      run_div(ra, rb, rs, 1'b0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_seq_32.md
DIV_SEQ_32 -- requirements
Module: div_seq_32

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning operand, quotient and remainder width; W SHALL be even and at least 4.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1, reset; reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, W, dividend; captured on the accepting edge.
REQ-006 The block SHALL have port B, input, W, divisor; captured on the accepting edge.
REQ-007 The block SHALL have port sgn, input, 1, signed-operation select; present only with DIV_SIGNED_EN.
REQ-008 The block SHALL have port Q, output, W, quotient, registered.
REQ-009 The block SHALL have port R, output, W, remainder, registered.
REQ-010 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-011 The block SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-012 The block SHALL have port dbz, output, 1, divide-by-zero flag for the current result.
REQ-013 The block SHALL have port ovf, output, 1, signed overflow flag for the current result.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and FIN.
REQ-015 IDLE with start=1: the accepting edge is edge 0; it captures the operands, clears the iteration counter and enters CALC.
REQ-015a Exception to REQ-015: if B=0, the FSM SHALL go to FIN instead.
REQ-016 CALC SHALL perform one restoring-division step per edge, W steps total.
REQ-016a Each step SHALL shift the partial remainder left by one and subtract the magnitude of the divisor.
REQ-016b If the subtraction result is non-negative, it SHALL be kept and the quotient bit is 1.
REQ-016c Otherwise the previous value SHALL be restored and the quotient bit is 0.
REQ-017 The partial remainder register SHALL be W+1 bits, so the subtraction borrow is the sign bit and no step overflows.
REQ-018 After the W-th step (edge W) the FSM SHALL enter FIN.
REQ-018a On edge W+1 the FSM SHALL register Q, R, dbz and ovf, pulse done high for exactly one cycle and return to IDLE.
REQ-019 busy SHALL be high from edge 0 until edge W+1; busy and done SHALL never be high in the same cycle.
REQ-020 start while busy SHALL be ignored; A and B changes after edge 0 SHALL NOT affect the result.
REQ-021 start held high SHALL begin a new division on the edge that returns the FSM to IDLE, so done can recur every W+2 cycles.
REQ-021a In the case of REQ-021, the first cycle of the new division is spent in IDLE.
REQ-022 Divide by zero SHALL give done after edge 1, with Q = all ones, R = A, dbz=1 and ovf=0.
REQ-023 Q, R, dbz and ovf SHALL hold their values until the next done.
REQ-024 Unsigned result: A = Q*B + R with 0 <= R < B.

Reset
REQ-025 RST_N=0 on a rising edge SHALL force IDLE.
REQ-025a The same edge SHALL force Q=0, R=0, busy=0, done=0, dbz=0, ovf=0 and counter=0.
REQ-026 Reset SHALL take priority over start and over any in-progress division.
REQ-026a A division aborted by reset SHALL NOT produce done.
REQ-027 The first start seen with RST_N=1 after reset SHALL be accepted on that edge.

Configuration
REQ-028 Macro DIV_SIGNED_EN SHALL control signed support.
REQ-028a Defined: the sgn port exists; with sgn=1 the operands are converted to magnitudes on edge 0 and the results are sign-corrected on edge W+1.
REQ-028b Defined, sign rules: the quotient is truncated toward zero and the remainder takes the dividend's sign.
REQ-028c Defined, overflow case: A = 0x80000000 (for W=32) divided by B = -1 SHALL give Q = 0x80000000, R=0 and ovf=1.
REQ-028d Defined, latency: the overflow case SHALL keep the normal latency.
REQ-029 Not defined: the sgn port is absent, all operands are unsigned and ovf is tied to 0.

Verification
REQ-030 Reset, then start with A=100, B=7 -> done exactly 33 cycles after the accepting edge, Q=14, R=2, dbz=0, ovf=0.
REQ-031 A=0xFFFFFFFF, B=1 -> Q=0xFFFFFFFF, R=0; then A=5, B=9 -> Q=0, R=5.
REQ-032 A=1234, B=0 -> done after edge 1, Q=0xFFFFFFFF, R=1234, dbz=1.
REQ-033 With DIV_SIGNED_EN, sgn=1:
- A=-7, B=2 -> Q=-3, R=-1.
- A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, ovf=1.
REQ-034 Operand change and second start mid-CALC -> first result unaffected, second start ignored. Assert RST_N=0 at step 10 -> no done, outputs zero, the next start is accepted normally.
REQ-035 start held high over 3 divisions -> done pulses exactly W+2 cycles apart, busy never high in a done cycle.
